uart_frame_parser: RTL
======================

// Module: uart_frame_parser
// PURPOSE
//  Generic byte-stream frame parser for the camera/host UART link: HEADER, PAYLOAD_BYTES data bytes, optional XOR checksum, TAIL.
//  Sits between the UART byte receiver and the application decoders (target X/Y, warehouse, angle).
//  Holds the last good frame stable, flags tail/checksum/timeout errors and keeps good/error frame statistics.
// PARAMETERS
//  PAYLOAD_BYTES  6         data bytes between header and tail (1..32)
//  HEADER         8'hFF     frame start byte
//  TAIL           8'hF1     frame end byte
//  CHK_EN         0         1: one XOR checksum byte follows the payload, before TAIL
//  TIMEOUT_CYC    500000    max Clk cycles between bytes inside a frame; 0 disables the timeout
//  CNT_W          16        width of frame_cnt
// PORTS
//  Clk          in   1                  system clock
//  rst          in   1                  synchronous reset, active-high
//  rx_data      in   8                  received byte, qualified by rx_valid
//  rx_valid     in   1                  one-cycle strobe, one per byte
//  payload      out  8*PAYLOAD_BYTES    last good frame; first received byte in [8*PAYLOAD_BYTES-1 -: 8]
//  frame_valid  out  1                  one-cycle pulse, payload just updated
//  err_tail     out  1                  one-cycle pulse, wrong tail byte
//  err_chk      out  1                  one-cycle pulse, checksum mismatch
//  err_timeout  out  1                  one-cycle pulse, inter-byte timeout
//  busy         out  1                  1 while state != IDLE
//  frame_cnt    out  CNT_W              good frames received, wraps to 0
//  err_cnt      out  8                  total error events, saturates at 255
// BEHAVIOUR
//  - Reset: state=IDLE; payload, frame_cnt, err_cnt = 0; all pulses and busy = 0; shadow buffer, index and checksum cleared.
//  - Reset overrides everything. A partial frame at reset is discarded.
//  - States:
//    IDLE: on rx_valid && rx_data==HEADER -> DATA; idx=0, chk=0. Any other byte is ignored.
//    DATA: each strobe stores the byte in shadow[idx] and does chk ^= byte.
//          After byte PAYLOAD_BYTES-1 -> CHK if CHK_EN, else -> TAIL.
//          Bytes equal to HEADER/TAIL are data here; no resync.
//    CHK:  on strobe, byte==chk -> TAIL; else err_chk pulse and -> IDLE.
//    TAIL: on strobe, byte==TAIL -> commit and -> IDLE; else err_tail pulse and -> IDLE.
//          A rejected byte is never re-examined as a header.
//  - Commit: payload <= shadow; frame_valid=1; frame_cnt+1. All are registered, visible the cycle after the TAIL strobe.
//    The parser is in IDLE that same cycle, so back-to-back frames lose no bytes.
//  - payload changes only on commit; bad frames never disturb it.
//  - Timeout:
//    - Counter is cleared on every strobe and counts while state != IDLE.
//    - At TIMEOUT_CYC without a strobe: err_timeout pulse, -> IDLE.
//    - A strobe in the same cycle as expiry wins: the byte is processed and there is no timeout.
//  - err_cnt increments by 1 per error pulse and holds at 255. Only one error source can fire per cycle.
//  - busy = (state != IDLE), registered.
// TESTING
//  1. PAYLOAD_BYTES=6, CHK_EN=0: FF 01 2C 78 03 00 5A F1.
//     -> frame_valid 1 cycle after F1; payload=48'h012C7803005A; frame_cnt=1.
//  2. Same frame with tail 0xF2.
//     -> err_tail pulse; payload unchanged (0 after reset); err_cnt=1; next byte FF starts a new frame.
//  3. CHK_EN=1: FF 10 20 30 40 50 60 70 F1 (XOR=70) -> frame accepted.
//     Checksum byte 71 -> err_chk, no commit.
//  4. TIMEOUT_CYC=100: FF 01 02, then idle 100 cycles -> err_timeout, busy=0.
//     Re-run with a strobe on cycle 100 -> no timeout.
//  5. Payload containing FF and F1 (FF FF F1 FF F1 00 00 F1) -> accepted; payload=48'hFFF1FFF10000.
//  6. Two frames back-to-back with no gap -> two frame_valid pulses, frame_cnt=2.
//     Assert rst mid-frame -> all outputs 0; next full frame accepted.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte input and frame result bundle for uart_frame_parser
interface uart_frame_parser_if #(
  parameter int unsigned PAYLOAD_BYTES = 6,
  parameter int unsigned CNT_W         = 16
);
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic                       frame_valid;
  logic                       err_tail;
  logic                       err_chk;
  logic                       err_timeout;
  logic                       busy;
  logic [CNT_W-1:0]           frame_cnt;
  logic [7:0]                 err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  payload, frame_valid, err_tail, err_chk, err_timeout, busy, frame_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output payload, frame_valid, err_tail, err_chk, err_timeout, busy, frame_cnt, err_cnt
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - HEADER/payload/optional XOR/TAIL frame parser with stats
module uart_frame_parser #(
  parameter int unsigned PAYLOAD_BYTES = 6,
  parameter logic [7:0]  HEADER        = 8'hFF,
  parameter logic [7:0]  TAIL          = 8'hF1,
  parameter bit          CHK_EN        = 1'b0,
  parameter int unsigned TIMEOUT_CYC   = 500000,
  parameter int unsigned CNT_W         = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  uart_frame_parser_if.slave bus
);
  localparam int unsigned IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, DATA, CHK, TAIL_ST} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [7:0]                 chk_q, chk_d;
  logic [8*PAYLOAD_BYTES-1:0] shadow_q, shadow_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic [CNT_W-1:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]                 err_cnt_q, err_cnt_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       err_tail_q, err_tail_d;
  logic                       err_chk_q, err_chk_d;
  logic                       err_timeout_q, err_timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      chk_q         <= '0;
      shadow_q      <= '0;
      payload_q     <= '0;
      tmo_q         <= '0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      err_tail_q    <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      shadow_q      <= shadow_d;
      payload_q     <= payload_d;
      tmo_q         <= tmo_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
      frame_valid_q <= frame_valid_d;
      err_tail_q    <= err_tail_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    shadow_d      = shadow_q;
    payload_d     = payload_q;
    tmo_d         = '0;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    frame_valid_d = 1'b0;
    err_tail_d    = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;

    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == HEADER) begin
            state_d = DATA;
            idx_d   = '0;
            chk_d   = '0;
          end
        end
        DATA: begin
          // Header/tail values are ordinary data here; no resync inside a frame
          shadow_d[8*(PAYLOAD_BYTES-1-int'(idx_q)) +: 8] = bus.rx_data;
          chk_d = chk_q ^ bus.rx_data;
          if (idx_q == LAST_IDX) state_d = CHK_EN ? CHK : TAIL_ST;
          else                   idx_d   = idx_q + 1'b1;
        end
        CHK: begin
          if (bus.rx_data == chk_q) begin
            state_d = TAIL_ST;
          end else begin
            err_chk_d = 1'b1;
            state_d   = IDLE;
          end
        end
        TAIL_ST: begin
          state_d = IDLE;
          if (bus.rx_data == TAIL) begin
            payload_d     = shadow_q;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 1'b1;
          end else begin
            err_tail_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && TIMEOUT_CYC != 0) begin
      // A strobe in the expiry cycle takes the branch above, so it always wins
      if (tmo_q == TMO_LAST) begin
        err_timeout_d = 1'b1;
        state_d       = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if ((err_tail_d || err_chk_d || err_timeout_d) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  assign bus.payload     = payload_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err_tail    = err_tail_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
endmodule
